// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared state encoding and default sizing for the register
//                file and the factorial datapath that uses it.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int c_DEF_WIDTH = 8;
    localparam int c_DEF_DEPTH = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } rf_state_e;

endpackage
`default_nettype wire

// File: rtl/regfile_clr_seq.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_clr_seq
//  Description : Clear sequencer: walks every entry writing zero after reset
//                or on a clear command, and flags busy while doing so.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int DEPTH = c_DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    rf_state_e     r_state_q;
    rf_state_e     w_state_d;
    logic [AW-1:0] r_ptr_q;
    logic [AW-1:0] w_ptr_d;

    always_comb begin
        w_state_d = r_state_q;
        w_ptr_d   = r_ptr_q;
        case (r_state_q)
            ST_IDLE: begin
                if (clr) begin
                    w_state_d = ST_CLEAR;
                    w_ptr_d   = '0;
                end
            end
            ST_CLEAR: begin
                // Pointer wraps back to zero on the final entry.
                w_ptr_d = r_ptr_q + AW'(1);
                if (r_ptr_q == AW'(DEPTH - 1)) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_CLEAR;
                w_ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= ST_CLEAR;
            r_ptr_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_ptr_q   <= w_ptr_d;
        end
    end

    // Reset restarts the walk without touching memory itself.
    assign busy     = (r_state_q == ST_CLEAR);
    assign clr_we   = busy && !rst;
    assign clr_addr = r_ptr_q;

endmodule
`default_nettype wire

// File: rtl/regfile_param.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_param
//  Description : Parametrised register file, one write port, NRD registered
//                read ports with valid flags, bypass and optional zero entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_param
    import regfile_pkg::*;
#(
    parameter  int WIDTH    = c_DEF_WIDTH,
    parameter  int DEPTH    = c_DEF_DEPTH,
    parameter  int NRD      = 2,
    parameter  int BYPASS   = 1,
    parameter  int ZERO_REG = 0,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    output logic                 busy,
    input  logic                 we,
    input  logic [AW-1:0]        wa,
    input  logic [WIDTH-1:0]     wd,
    input  logic [NRD-1:0]       re,
    input  logic [NRD*AW-1:0]    ra,
    output logic [NRD*WIDTH-1:0] rd,
    output logic [NRD-1:0]       rd_vld
);

    logic             w_busy;
    logic             w_clr_we;
    logic [AW-1:0]    w_clr_addr;
    logic             w_wr_en;
    logic [WIDTH-1:0] r_mem_q [DEPTH];
    logic [WIDTH-1:0] w_mem_d [DEPTH];

    regfile_clr_seq #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clr_seq (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .busy     (w_busy),
        .clr_we   (w_clr_we),
        .clr_addr (w_clr_addr)
    );

    assign busy = w_busy;

    // Writes arriving while clearing are dropped, not queued.
    always_comb begin
        w_wr_en = we && !w_busy && !((ZERO_REG != 0) && (wa == '0));
    end

    always_comb begin
        w_mem_d = r_mem_q;
        if (w_clr_we) begin
            w_mem_d[w_clr_addr] = '0;
        end else if (w_wr_en) begin
            w_mem_d[wa] = wd;
        end
    end

    always_ff @(posedge clk) begin
        r_mem_q <= w_mem_d;
    end

    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd_port
        logic [AW-1:0]    w_ra;
        logic [WIDTH-1:0] w_data;
        logic [WIDTH-1:0] w_rd_d;
        logic             w_vld_d;
        logic [WIDTH-1:0] r_rd_q;
        logic             r_vld_q;

        assign w_ra = ra[gi*AW +: AW];

        always_comb begin
            w_data = r_mem_q[w_ra];
            if ((ZERO_REG != 0) && (w_ra == '0)) begin
                w_data = '0;
            end else if ((BYPASS != 0) && w_wr_en && (wa == w_ra)) begin
                w_data = wd;
            end
            w_vld_d = re[gi] && !w_busy;
            w_rd_d  = w_vld_d ? w_data : '0;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_rd_q  <= '0;
                r_vld_q <= 1'b0;
            end else begin
                r_rd_q  <= w_rd_d;
                r_vld_q <= w_vld_d;
            end
        end

        assign rd[gi*WIDTH +: WIDTH] = r_rd_q;
        assign rd_vld[gi]            = r_vld_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_param
//  Description : Self-checking bench for regfile_param: default, no-bypass
//                and zero-entry/four-port instances driven in lockstep.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_param;

    typedef struct {
        string       name;
        logic        rst;
        logic        clr;
        logic        we;
        logic [1:0]  wa;
        logic [7:0]  wd;
        logic [1:0]  re;
        logic [3:0]  ra;
        logic [3:0]  re4;
        logic [7:0]  ra4;
        logic        e_busy;
        logic [1:0]  e_vld;
        logic [15:0] e_rd;
        logic        e_nvld;
        logic [7:0]  e_nrd;
        logic [3:0]  e_zvld;
        logic [31:0] e_zrd;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, clr, we;
    logic [1:0]  wa;
    logic [7:0]  wd;
    logic [1:0]  re;
    logic [3:0]  ra;
    logic [3:0]  re4;
    logic [7:0]  ra4;
    logic        busy, busy_nb, busy_z;
    logic [15:0] rd, rd_nb;
    logic [1:0]  rd_vld, rd_vld_nb;
    logic [31:0] rd_z;
    logic [3:0]  rd_vld_z;

    int   n_chk  = 0;
    int   n_fail = 0;
    vec_t vq[$];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    regfile_param #(.WIDTH(8), .DEPTH(4), .NRD(2), .BYPASS(1), .ZERO_REG(0)) u_dut (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy), .we(we), .wa(wa), .wd(wd),
        .re(re), .ra(ra), .rd(rd), .rd_vld(rd_vld)
    );

    regfile_param #(.WIDTH(8), .DEPTH(4), .NRD(2), .BYPASS(0), .ZERO_REG(0)) u_nb (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy_nb), .we(we), .wa(wa), .wd(wd),
        .re(re), .ra(ra), .rd(rd_nb), .rd_vld(rd_vld_nb)
    );

    regfile_param #(.WIDTH(8), .DEPTH(4), .NRD(4), .BYPASS(1), .ZERO_REG(1)) u_z (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy_z), .we(we), .wa(wa), .wd(wd),
        .re(re4), .ra(ra4), .rd(rd_z), .rd_vld(rd_vld_z)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input string nm, input logic r, input logic c, input logic w,
                       input logic [1:0] a, input logic [7:0] d, input logic [1:0] e,
                       input logic [3:0] ea, input logic [3:0] e4, input logic [7:0] ea4,
                       input logic xb, input logic [1:0] xv, input logic [15:0] xr,
                       input logic xnv, input logic [7:0] xnr, input logic [3:0] xzv,
                       input logic [31:0] xzr);
        vec_t v;
        v.name = nm; v.rst = r; v.clr = c; v.we = w; v.wa = a; v.wd = d;
        v.re = e; v.ra = ea; v.re4 = e4; v.ra4 = ea4;
        v.e_busy = xb; v.e_vld = xv; v.e_rd = xr; v.e_nvld = xnv; v.e_nrd = xnr;
        v.e_zvld = xzv; v.e_zrd = xzr;
        vq.push_back(v);
    endtask

    task automatic apply(input vec_t v, input int idx);
        vec_t  e;
        string t;
        @(negedge clk);
        rst = v.rst; clr = v.clr; we = v.we; wa = v.wa; wd = v.wd;
        re = v.re; ra = v.ra; re4 = v.re4; ra4 = v.ra4;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        t = $sformatf("%0d:%s", idx, e.name);
        chk({t, ".busy"},   {31'd0, busy},      {31'd0, e.e_busy});
        chk({t, ".busy_z"}, {31'd0, busy_z},    {31'd0, e.e_busy});
        chk({t, ".vld"},    {30'd0, rd_vld},    {30'd0, e.e_vld});
        chk({t, ".rd"},     {16'd0, rd},        {16'd0, e.e_rd});
        chk({t, ".nb_vld"}, {31'd0, rd_vld_nb[0]}, {31'd0, e.e_nvld});
        chk({t, ".nb_rd0"}, {24'd0, rd_nb[7:0]},   {24'd0, e.e_nrd});
        chk({t, ".z_vld"},  {28'd0, rd_vld_z},  {28'd0, e.e_zvld});
        chk({t, ".z_rd"},   rd_z,               e.e_zrd);
    endtask

    initial begin
        int cnt;
        rst = 1'b0; clr = 1'b0; we = 1'b0; wa = '0; wd = '0;
        re = '0; ra = '0; re4 = '0; ra4 = '0;

        // name        rst clr we wa wd     re ra    re4   ra4     busy vld rd        nv nrd    zv    zrd
        add("rst",       1, 0, 0, 0, 8'h00, 0, 4'h0, 4'h0, 8'h00,  1, 0, 16'h0000, 0, 8'h00, 4'h0, 32'h0);
        for (int i = 0; i < 3; i++)
        add("clr_busy",  0, 0, 0, 0, 8'h00, 3, 4'hC, 4'hF, 8'h00,  1, 0, 16'h0000, 0, 8'h00, 4'h0, 32'h0);
        add("clr_last",  0, 0, 0, 0, 8'h00, 3, 4'hC, 4'hF, 8'h00,  0, 0, 16'h0000, 0, 8'h00, 4'h0, 32'h0);
        add("post_rd",   0, 0, 0, 0, 8'h00, 3, 4'hC, 4'hF, 8'h00,  0, 3, 16'h0000, 1, 8'h00, 4'hF, 32'h0);
        add("wr1",       0, 0, 1, 1, 8'hA5, 0, 4'h0, 4'h0, 8'h00,  0, 0, 16'h0000, 0, 8'h00, 4'h0, 32'h0);
        add("wr2",       0, 0, 1, 2, 8'h3C, 0, 4'h0, 4'h0, 8'h00,  0, 0, 16'h0000, 0, 8'h00, 4'h0, 32'h0);
        add("rd12",      0, 0, 0, 0, 8'h00, 3, 4'h9, 4'hF, 8'h55,  0, 3, 16'h3CA5, 1, 8'hA5, 4'hF, 32'hA5A5A5A5);
        add("bypass",    0, 0, 1, 2, 8'h77, 1, 4'h2, 4'h1, 8'h02,  0, 1, 16'h0077, 1, 8'h3C, 4'h1, 32'h77);
        add("after_byp", 0, 0, 0, 0, 8'h00, 1, 4'h2, 4'h1, 8'h02,  0, 1, 16'h0077, 1, 8'h77, 4'h1, 32'h77);
        add("zr_wr0",    0, 0, 1, 0, 8'h99, 0, 4'h0, 4'h1, 8'h00,  0, 0, 16'h0000, 0, 8'h00, 4'h1, 32'h0);
        add("zr_rd0",    0, 0, 0, 0, 8'h00, 1, 4'h0, 4'h1, 8'h00,  0, 1, 16'h0099, 1, 8'h99, 4'h1, 32'h0);
        add("fill0",     0, 0, 1, 0, 8'h11, 0, 4'h0, 4'h0, 8'h00,  0, 0, 16'h0000, 0, 8'h00, 4'h0, 32'h0);
        add("fill1",     0, 0, 1, 1, 8'h22, 0, 4'h0, 4'h0, 8'h00,  0, 0, 16'h0000, 0, 8'h00, 4'h0, 32'h0);
        add("fill2",     0, 0, 1, 2, 8'h33, 0, 4'h0, 4'h0, 8'h00,  0, 0, 16'h0000, 0, 8'h00, 4'h0, 32'h0);
        add("fill3",     0, 0, 1, 3, 8'h44, 0, 4'h0, 4'h0, 8'h00,  0, 0, 16'h0000, 0, 8'h00, 4'h0, 32'h0);
        add("clr_cmd",   0, 1, 0, 0, 8'h00, 0, 4'h0, 4'h0, 8'h00,  1, 0, 16'h0000, 0, 8'h00, 4'h0, 32'h0);
        add("clr_wr3",   0, 1, 1, 3, 8'hFF, 3, 4'hC, 4'h0, 8'h00,  1, 0, 16'h0000, 0, 8'h00, 4'h0, 32'h0);
        add("clr_busy2", 0, 0, 0, 0, 8'h00, 0, 4'h0, 4'h0, 8'h00,  1, 0, 16'h0000, 0, 8'h00, 4'h0, 32'h0);
        add("clr_wr0",   0, 0, 1, 0, 8'hFF, 0, 4'h0, 4'h0, 8'h00,  1, 0, 16'h0000, 0, 8'h00, 4'h0, 32'h0);
        add("clr_done",  0, 0, 0, 0, 8'h00, 0, 4'h0, 4'h0, 8'h00,  0, 0, 16'h0000, 0, 8'h00, 4'h0, 32'h0);
        add("rd_01",     0, 0, 0, 0, 8'h00, 3, 4'h4, 4'hF, 8'hE4,  0, 3, 16'h0000, 1, 8'h00, 4'hF, 32'h0);
        add("rd_23",     0, 0, 0, 0, 8'h00, 3, 4'hE, 4'hF, 8'hE4,  0, 3, 16'h0000, 1, 8'h00, 4'hF, 32'h0);
        add("wr1b",      0, 0, 1, 1, 8'h5A, 0, 4'h0, 4'h0, 8'h00,  0, 0, 16'h0000, 0, 8'h00, 4'h0, 32'h0);
        add("wr3b",      0, 0, 1, 3, 8'hC3, 0, 4'h0, 4'h0, 8'h00,  0, 0, 16'h0000, 0, 8'h00, 4'h0, 32'h0);
        add("clr_wr",    0, 1, 1, 2, 8'hEE, 0, 4'h0, 4'h0, 8'h00,  1, 0, 16'h0000, 0, 8'h00, 4'h0, 32'h0);
        add("rst_mid",   1, 0, 0, 0, 8'h00, 3, 4'hD, 4'h0, 8'h00,  1, 0, 16'h0000, 0, 8'h00, 4'h0, 32'h0);
        add("clr_ign",   0, 1, 0, 0, 8'h00, 0, 4'h0, 4'h0, 8'h00,  1, 0, 16'h0000, 0, 8'h00, 4'h0, 32'h0);
        add("rst_busy",  0, 0, 0, 0, 8'h00, 0, 4'h0, 4'h0, 8'h00,  1, 0, 16'h0000, 0, 8'h00, 4'h0, 32'h0);
        add("rst_busy",  0, 0, 0, 0, 8'h00, 0, 4'h0, 4'h0, 8'h00,  1, 0, 16'h0000, 0, 8'h00, 4'h0, 32'h0);
        add("rst_done",  0, 0, 0, 0, 8'h00, 0, 4'h0, 4'h0, 8'h00,  0, 0, 16'h0000, 0, 8'h00, 4'h0, 32'h0);
        add("rd_13",     0, 0, 0, 0, 8'h00, 3, 4'hD, 4'hF, 8'hE4,  0, 3, 16'h0000, 1, 8'h00, 4'hF, 32'h0);
        add("rd_02",     0, 0, 0, 0, 8'h00, 3, 4'h8, 4'hF, 8'hE4,  0, 3, 16'h0000, 1, 8'h00, 4'hF, 32'h0);

        for (int i = 0; i < vq.size(); i++) begin
            apply(vq[i], i);
        end

        // Registered read output is cleared by reset.
        @(negedge clk); rst = 1'b0; clr = 1'b0; we = 1'b1; wa = 2'd1; wd = 8'h5C; re = '0; re4 = '0;
        @(negedge clk); we = 1'b0; re = 2'b01; ra = 4'h1;
        @(posedge clk); #1;
        chk("seq.rd_before_rst", {16'd0, rd}, 32'h005C);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("seq.rd_on_rst",  {16'd0, rd},     32'h0);
        chk("seq.vld_on_rst", {30'd0, rd_vld}, 32'h0);

        // Hold reset for three more cycles, then time the clear tail.
        @(negedge clk); re = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); rst = 1'b1;
            @(posedge clk); #1;
            chk("seq.busy_in_rst", {31'd0, busy}, 32'd1);
        end
        @(negedge clk); rst = 1'b0;
        cnt = 1;
        for (int k = 0; k < 20 && busy; k++) begin
            @(posedge clk); #1;
            if (busy) cnt++;
        end
        chk("seq.busy_not_stuck",   {31'd0, busy}, 32'd0);
        chk("seq.busy_after_release", cnt, 32'd4);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
